// File: rtl/wordcopy_stream.sv
// Purpose: strided word-copy DMA: CPU programs registers, engine streams COUNT words SRC -> DST over an Avalon-MM master.
// Latency: register reads return one cycle after an accepted strobe; copy throughput is up to one master beat per cycle.
// Backpressure: master commands hold until master_waitrequest drops; CTRL accesses stall the CPU (slave_waitrequest) while busy.
//
// Ports:
//   clk, rst_n            clock; rst_n is an asynchronous ACTIVE-HIGH reset despite its name
//   slave_*               CPU register file (word offsets 0..7), waitrequest only asserted for CTRL while busy
//   master_*              copy master: pipelined reads, in-order readdatavalid with any latency >= 1
//
// Register map: 0 CTRL (wr: start, rd: {done,busy}), 1 DST, 2 SRC, 3 COUNT, 4 SRC_STRIDE,
//               5 DST_STRIDE, 6 WORDS_DONE (ro), 7 FILL pattern (only with the optional feature).
// Optional feature: define WORDCOPY_FILL_EN to enable fill mode (CTRL write bit 1) and the FILL register.

module wordcopy_stream #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    output logic [31:0]       slave_readdata,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    input  logic [DATA_W-1:0] master_readdata,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_readdatavalid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [CW:0]       DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]     ONE_CW     = CW'(1);
    localparam logic [CNT_W-1:0]  ONE_CNT    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // CPU-visible registers
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  src_stride_reg;
    logic [CNT_W-1:0]  dst_stride_reg;
    logic [CNT_W-1:0]  words_done;
    logic              done_reg;

    // Per-copy working state, latched at start
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] src_step;
    logic [ADDR_W-1:0] dst_step;
    logic [CNT_W-1:0]  rd_issued;
    logic [CNT_W-1:0]  wr_issued;

    // Read-data buffer
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     fifo_wr_ptr;
    logic [PW-1:0]     fifo_rd_ptr;
    logic [CW-1:0]     fifo_count;
    // Reads loaded into the command register whose data has not come back yet
    // (includes a read still waiting on master_waitrequest).
    logic [CW-1:0]     outstanding;

    logic              busy;
    logic              issue_en;
    logic              fill_active;
    logic [DATA_W-1:0] wr_src_data;

`ifdef WORDCOPY_FILL_EN
    logic              fill_mode_q;
    logic [DATA_W-1:0] fill_reg;
    assign fill_active = fill_mode_q;
    assign wr_src_data = fill_mode_q ? fill_reg : fifo_mem[fifo_rd_ptr];
`else
    assign fill_active = 1'b0;
    assign wr_src_data = fifo_mem[fifo_rd_ptr];
`endif

    // ------------------------------------------------------------------
    // Slave handshake
    // ------------------------------------------------------------------
    logic sl_rd_acc;
    logic sl_wr_acc;
    logic start;
    logic cfg_we;

    // Only CTRL stalls; it resolves combinationally once the FSM returns to IDLE,
    // so a start issued while busy becomes a fresh start right after completion.
    assign slave_waitrequest = busy && (slave_read || slave_write) && (slave_address == 4'd0);
    assign sl_rd_acc = slave_read  && !slave_waitrequest;
    assign sl_wr_acc = slave_write && !slave_waitrequest;
    assign start     = sl_wr_acc && (slave_address == 4'd0);
    assign cfg_we    = sl_wr_acc && !busy;

    // ------------------------------------------------------------------
    // Master issue logic
    // ------------------------------------------------------------------
    logic          m_rd_acc;
    logic          m_wr_acc;
    logic          slot_free;
    logic          push;
    logic          pop;
    logic          wr_avail;
    logic          rd_avail;
    logic          load_wr;
    logic          load_rd;
    logic [CW:0]   occupancy;

    assign m_rd_acc  = master_read  && !master_waitrequest;
    assign m_wr_acc  = master_write && !master_waitrequest;
    // The command register can take a new command if empty or if its current one is accepted this cycle.
    assign slot_free = !(master_read || master_write) || !master_waitrequest;
    // Returns after a reset abort find outstanding==0 and are dropped.
    assign push      = master_readdatavalid && busy && (outstanding != '0);
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

    assign wr_avail  = fill_active ? (wr_issued != cnt_q) : (fifo_count != '0);
    assign rd_avail  = !fill_active && (rd_issued != cnt_q) && (occupancy < DEPTH_C);
    // Writes win over reads so the buffer drains and the read window reopens.
    assign load_wr   = issue_en && slot_free && wr_avail;
    assign load_rd   = issue_en && slot_free && !wr_avail && rd_avail;
    assign pop       = load_wr && !fill_active;

    // ------------------------------------------------------------------
    // Completion conditions
    // ------------------------------------------------------------------
    logic [CNT_W:0] words_done_p1;
    logic           all_written;
    logic           reads_done;

    assign words_done_p1 = {1'b0, words_done} + {1'b0, ONE_CNT};
    // Evaluated with this cycle's acceptance so the copy retires on the edge of the last write.
    assign all_written   = (words_done == cnt_q) || (m_wr_acc && (words_done_p1 == {1'b0, cnt_q}));
    assign reads_done    = fill_active || ((rd_issued == cnt_q) && !(master_read && !m_rd_acc));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                // Direct exit covers COUNT=0: exactly one busy cycle.
                if (all_written && (outstanding == '0)) state_nxt = S_IDLE;
                else if (reads_done)                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (all_written && (outstanding == '0)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b0;
        issue_en = 1'b0;
        case (state)
            S_RUN, S_DRAIN: begin
                busy     = 1'b1;
                issue_en = 1'b1;
            end
            default: begin
                busy     = 1'b0;
                issue_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dst_reg        <= '0;
            src_reg        <= '0;
            count_reg      <= '0;
            src_stride_reg <= ONE_CNT;
            dst_stride_reg <= ONE_CNT;
            slave_readdata <= '0;
`ifdef WORDCOPY_FILL_EN
            fill_reg       <= '0;
`endif
        end else begin
            if (cfg_we) begin
                case (slave_address)
                    4'd1: dst_reg        <= ADDR_W'(slave_writedata);
                    4'd2: src_reg        <= ADDR_W'(slave_writedata);
                    4'd3: count_reg      <= slave_writedata[CNT_W-1:0];
                    4'd4: src_stride_reg <= slave_writedata[CNT_W-1:0];
                    4'd5: dst_stride_reg <= slave_writedata[CNT_W-1:0];
`ifdef WORDCOPY_FILL_EN
                    4'd7: fill_reg       <= DATA_W'(slave_writedata);
`endif
                    default: ;
                endcase
            end
            if (sl_rd_acc) begin
                case (slave_address)
                    4'd0:    slave_readdata <= {30'b0, done_reg, busy};
                    4'd1:    slave_readdata <= 32'(dst_reg);
                    4'd2:    slave_readdata <= 32'(src_reg);
                    4'd3:    slave_readdata <= 32'(count_reg);
                    4'd4:    slave_readdata <= 32'(src_stride_reg);
                    4'd5:    slave_readdata <= 32'(dst_stride_reg);
                    4'd6:    slave_readdata <= 32'(words_done);
`ifdef WORDCOPY_FILL_EN
                    4'd7:    slave_readdata <= 32'(fill_reg);
`endif
                    default: slave_readdata <= '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Copy datapath: command register, address generators, counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            cnt_q            <= '0;
            rd_addr          <= '0;
            wr_addr          <= '0;
            src_step         <= '0;
            dst_step         <= '0;
            rd_issued        <= '0;
            wr_issued        <= '0;
            words_done       <= '0;
            done_reg         <= 1'b0;
`ifdef WORDCOPY_FILL_EN
            fill_mode_q      <= 1'b0;
`endif
        end else begin
            if (start) begin
                cnt_q      <= count_reg;
                rd_addr    <= src_reg;
                wr_addr    <= dst_reg;
                src_step   <= ADDR_W'(src_stride_reg) * WORD_BYTES;
                dst_step   <= ADDR_W'(dst_stride_reg) * WORD_BYTES;
                rd_issued  <= '0;
                wr_issued  <= '0;
                words_done <= '0;
                done_reg   <= 1'b0;
`ifdef WORDCOPY_FILL_EN
                fill_mode_q <= slave_writedata[1];
`endif
            end

            if (busy && (state_nxt == S_IDLE)) done_reg <= 1'b1;

            if (m_wr_acc) words_done <= words_done + ONE_CNT;

            if (load_wr) begin
                master_write     <= 1'b1;
                master_read      <= 1'b0;
                master_address   <= wr_addr;
                master_writedata <= wr_src_data;
                wr_addr          <= wr_addr + dst_step;
                wr_issued        <= wr_issued + ONE_CNT;
            end else if (load_rd) begin
                master_read      <= 1'b1;
                master_write     <= 1'b0;
                master_address   <= rd_addr;
                rd_addr          <= rd_addr + src_step;
                rd_issued        <= rd_issued + ONE_CNT;
            end else if (slot_free) begin
                master_read      <= 1'b0;
                master_write     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-data FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
        end else begin
            if (push) fifo_wr_ptr <= fifo_wr_ptr + PW'(1);
            if (pop)  fifo_rd_ptr <= fifo_rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + ONE_CW;
                2'b01:   fifo_count <= fifo_count - ONE_CW;
                default: fifo_count <= fifo_count;
            endcase
            case ({load_rd, push})
                2'b10:   outstanding <= outstanding + ONE_CW;
                2'b01:   outstanding <= outstanding - ONE_CW;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[fifo_wr_ptr] <= master_readdata;
    end

endmodule
